// File: rtl/ball_collide.sv
// ball_collide: Pong ball engine with motion, wall/paddle bounces, misses, scoring and serve/play/point/over sequencing
module ball_collide #(
    parameter int X_MAX       = 639,
    parameter int Y_TOP       = 38,
    parameter int Y_BOT       = 511,
    parameter int LPAD_X      = 60,
    parameter int RPAD_X      = 580,
    parameter int PAD_HALF    = 50,
    parameter int BALL_R      = 4,
    parameter int CENTER_X    = 320,
    parameter int CENTER_Y    = 274,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [9:0] ypos_left,
    input  logic [9:0] ypos_right,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       hit,
    output logic       point,
    output logic       game_over
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;
    localparam int CW = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_TICKS - 1);
    localparam logic [10:0] TOP_LIM = 11'(Y_TOP + BALL_R + 1);
    localparam logic [10:0] BOT_LIM = 11'(Y_BOT - BALL_R - 1);
    localparam logic [10:0] LFACE   = 11'(LPAD_X + BALL_R + 1);
    localparam logic [10:0] RFACE   = 11'(RPAD_X - BALL_R - 1);
    localparam logic [10:0] LMISS   = 11'(BALL_R);
    localparam logic [10:0] RMISS   = 11'(X_MAX - BALL_R);
    localparam logic [10:0] REACH   = 11'(PAD_HALF + BALL_R);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic dir_x, dir_y, serve_dy, scorer;
    logic dx_n, dy_n, sdy_n, scorer_n, hit_n, point_n;
    logic [9:0] x_n, y_n;
    logic [3:0] sl_n, sr_n, inc;
    logic [10:0] bx, by, adl, adr;
    logic face, flip_y, miss;

    // dir_x 1 = right, dir_y 1 = down, scorer 1 = left player scored
    assign bx        = {1'b0, ball_x};
    assign by        = {1'b0, ball_y};
    assign adl       = ball_y >= ypos_left ? by - {1'b0, ypos_left} : {1'b0, ypos_left} - by;
    assign adr       = ball_y >= ypos_right ? by - {1'b0, ypos_right} : {1'b0, ypos_right} - by;
    assign miss      = dir_x ? bx == RMISS : bx == LMISS;
    assign face      = dir_x ? bx == RFACE && adr <= REACH : bx == LFACE && adl <= REACH;
    assign flip_y    = dir_y ? by > BOT_LIM : by < TOP_LIM;
    assign inc       = (scorer ? score_left : score_right) + 4'd1;
    assign game_over = state == OVER;

    // next-state and datapath: the new direction on each axis decides the step taken this tick
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        x_n      = ball_x;
        y_n      = ball_y;
        dx_n     = dir_x;
        dy_n     = dir_y;
        sdy_n    = serve_dy;
        scorer_n = scorer;
        sl_n     = score_left;
        sr_n     = score_right;
        hit_n    = 1'b0;
        point_n  = 1'b0;
        case (state)
            SERVE: if (tick) begin
                cnt_n   = cnt == CNT_LAST ? {CW{1'b0}} : cnt + 1'b1;
                state_n = cnt == CNT_LAST ? PLAY : SERVE;
            end
            PLAY: if (tick && miss) begin
                scorer_n = dir_x;
                state_n  = POINT;
            end else if (tick) begin
                dy_n  = dir_y ^ flip_y;
                y_n   = dy_n ? ball_y + 10'd1 : ball_y - 10'd1;
                dx_n  = dir_x ^ face;
                x_n   = dx_n ? ball_x + 10'd1 : ball_x - 10'd1;
                hit_n = face;
            end
            POINT: begin
                point_n = 1'b1;
                sl_n    = scorer ? inc : score_left;
                sr_n    = scorer ? score_right : inc;
                state_n = inc == 4'(WIN_SCORE) ? OVER : SERVE;
                x_n     = 10'(CENTER_X);
                y_n     = 10'(CENTER_Y);
                dx_n    = scorer;
                sdy_n   = ~serve_dy;
                dy_n    = ~serve_dy;
            end
            default: ;
        endcase
    end

    // state and datapath registers with synchronous reset to a fresh serve
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SERVE;
            cnt         <= '0;
            ball_x      <= 10'(CENTER_X);
            ball_y      <= 10'(CENTER_Y);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            serve_dy    <= 1'b1;
            scorer      <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            hit         <= 1'b0;
            point       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ball_x      <= x_n;
            ball_y      <= y_n;
            dir_x       <= dx_n;
            dir_y       <= dy_n;
            serve_dy    <= sdy_n;
            scorer      <= scorer_n;
            score_left  <= sl_n;
            score_right <= sr_n;
            hit         <= hit_n;
            point       <= point_n;
        end
    end
endmodule

// File: tb/tb_ball_collide.sv
// tb_ball_collide: scoreboard bench for the Pong ball engine
module tb_ball_collide;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [9:0] ypos_left = '0;
    logic [9:0] ypos_right = '0;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_left, score_right;
    logic       hit, point, game_over;
    int cyc = 0, ntk = 0, checks = 0, errors = 0;
    bit done = 1'b0, timeout = 1'b0;

    typedef struct {int cyc; int x; int y; int sl; int sr; int go;} pos_t;
    typedef struct {int tk; int h; int p; int sl; int sr;} pulse_t;
    pos_t   pq[$];
    pulse_t eq[$];

    ball_collide dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ypos_left(ypos_left), .ypos_right(ypos_right),
        .ball_x(ball_x), .ball_y(ball_y),
        .score_left(score_left), .score_right(score_right),
        .hit(hit), .point(point), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // cycle stamp and ticks-since-reset, both derived from the bench's own stimulus
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ntk <= rst ? 0 : ntk + int'(tick);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upto(int k);
        int guard = 0;
        while (ntk < k && guard < 5000) begin
            step();
            guard++;
        end
        if (ntk != k) timeout = 1'b1;
    endtask

    task automatic chk(int x, int y, int sl, int sr, int go);
        pos_t p;
        p.cyc = cyc; p.x = x; p.y = y; p.sl = sl; p.sr = sr; p.go = go;
        pq.push_back(p);
    endtask

    task automatic exp_pulse(int tk, int h, int p, int sl, int sr);
        pulse_t e;
        e.tk = tk; e.h = h; e.p = p; e.sl = sl; e.sr = sr;
        eq.push_back(e);
    endtask

    // monitor: compares positions at scheduled cycles and every hit/point pulse the DUT emits
    always @(negedge clk) begin : monitor
        pos_t p;
        pulse_t e;
        if (pq.size() != 0 && pq[0].cyc == cyc) begin
            p = pq.pop_front();
            checks++;
            if (int'(ball_x) != p.x || int'(ball_y) != p.y || int'(score_left) != p.sl ||
                int'(score_right) != p.sr || int'(game_over) != p.go) begin
                errors++;
                $display("FAIL pos tick=%0d got (%0d,%0d) L=%0d R=%0d over=%0d required (%0d,%0d) L=%0d R=%0d over=%0d",
                         ntk, ball_x, ball_y, score_left, score_right, game_over, p.x, p.y, p.sl, p.sr, p.go);
            end
        end
        if (hit || point) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL pulse tick=%0d got hit=%0d point=%0d required no pulse", ntk, hit, point);
            end else begin
                e = eq.pop_front();
                if (e.tk != ntk || e.h != int'(hit) || e.p != int'(point) ||
                    e.sl != int'(score_left) || e.sr != int'(score_right)) begin
                    errors++;
                    $display("FAIL pulse got tick=%0d hit=%0d point=%0d L=%0d R=%0d required tick=%0d hit=%0d point=%0d L=%0d R=%0d",
                             ntk, hit, point, score_left, score_right, e.tk, e.h, e.p, e.sl, e.sr);
                end
            end
        end
        if (done) begin
            checks++;
            if (timeout) begin
                errors++;
                $display("FAIL budget got timeout=1 required 0");
            end
            checks++;
            if (eq.size() != 0 || pq.size() != 0) begin
                errors++;
                $display("FAIL leftover got pulses=%0d positions=%0d required 0 0", eq.size(), pq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        ypos_left  = 10'd0;
        ypos_right = 10'd485;
        exp_pulse(316, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) exp_pulse(888 + 378 * i, 0, 1, 0, i + 1);
        step();
        step();
        chk(320, 274, 0, 0, 0);
        rst  = 1'b0;
        tick = 1'b1;
        upto(1);    chk(320, 274, 0, 0, 0);
        upto(60);   chk(320, 274, 0, 0, 0);
        upto(61);   chk(321, 275, 0, 0, 0);
        upto(100);  chk(360, 314, 0, 0, 0);
        tick = 1'b0;
        repeat (3) begin
            step();
            chk(360, 314, 0, 0, 0);
        end
        tick = 1'b1;
        upto(293);  chk(553, 507, 0, 0, 0);
        upto(294);  chk(554, 506, 0, 0, 0);
        upto(315);  chk(575, 485, 0, 0, 0);
        upto(316);  chk(574, 484, 0, 0, 0);
        upto(317);  chk(573, 483, 0, 0, 0);
        upto(758);  chk(132, 42, 0, 0, 0);
        upto(759);  chk(131, 43, 0, 0, 0);
        upto(886);  chk(4, 170, 0, 0, 0);
        upto(887);  chk(4, 170, 0, 0, 0);
        upto(888);  chk(320, 274, 0, 1, 0);
        upto(948);  chk(320, 274, 0, 1, 0);
        upto(949);  chk(319, 273, 0, 1, 0);
        upto(3156); chk(320, 274, 0, 7, 1);
        upto(3200); chk(320, 274, 0, 7, 1);
        rst = 1'b1;
        step();
        chk(320, 274, 0, 0, 0);
        rst = 1'b0;
        ypos_right = 10'd200;
        exp_pulse(377, 0, 1, 1, 0);
        upto(60);   chk(320, 274, 0, 0, 0);
        upto(61);   chk(321, 275, 0, 0, 0);
        upto(316);  chk(576, 484, 0, 0, 0);
        upto(375);  chk(635, 425, 0, 0, 0);
        upto(376);  chk(635, 425, 0, 0, 0);
        upto(377);  chk(320, 274, 1, 0, 0);
        upto(438);  chk(321, 273, 1, 0, 0);
        upto(450);  chk(333, 261, 1, 0, 0);
        rst = 1'b1;
        step();
        chk(320, 274, 0, 0, 0);
        rst = 1'b0;
        upto(59);   chk(320, 274, 0, 0, 0);
        upto(60);   chk(320, 274, 0, 0, 0);
        upto(61);   chk(321, 275, 0, 0, 0);
        step();
        step();
        done = 1'b1;
    end
endmodule

// File: doc/ball_collide.md
Name: ball_collide

Overview:
- Ball engine for Pong. Consumes the left and right paddle centre positions produced by the paddle mover.
- Moves the ball one pixel per axis per tick, bounces it off the top and bottom walls and the paddle faces, and detects misses.
- Keeps score and sequences serve, play, point and game-over.
- Outputs feed the VGA renderer and the score display.

Parameters:
- X_MAX, 639, rightmost pixel column; X_MIN is fixed at 0.
- Y_TOP, 38, top wall row (same bound as paddle travel).
- Y_BOT, 511, bottom wall row (same bound as paddle travel).
- LPAD_X, 60, column of the left paddle's inner face.
- RPAD_X, 580, column of the right paddle's inner face.
- PAD_HALF, 50, paddle half-height (same as the paddle mover).
- BALL_R, 4, ball half-size.
- CENTER_X, 320, serve x.
- CENTER_Y, 274, serve y.
- SERVE_TICKS, 60, ticks spent in SERVE before play.
- WIN_SCORE, 7, score that ends the game.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  frame-step enable, one-cycle pulse
- ypos_left  in  10  left paddle centre y
- ypos_right  in  10  right paddle centre y
- ball_x  out  10  ball centre x
- ball_y  out  10  ball centre y
- score_left  out  4  left player score
- score_right  out  4  right player score
- hit  out  1  one-cycle pulse on a paddle hit
- point  out  1  one-cycle pulse on a score
- game_over  out  1  high while in state OVER

Behaviour:
- Clocking and reset:
  - One clock. rst is synchronous and active-high; it is sampled on posedge clk and overrides everything.
  - Reset state: state = SERVE, ball = (CENTER_X, CENTER_Y), dir_x = right, dir_y = down, serve counter = 0.
  - Reset outputs: scores = 0; hit, point and game_over = 0.
  - Reset mid-play or mid-OVER has identical effect.
- Arithmetic:
  - All position compares use at least 11 bits, so nothing wraps.
  - ypos inputs are sampled in the same cycle as the tick that uses them.
- SERVE:
  - Ball is held at the centre.
  - Each tick increments the serve counter. On the tick where the counter equals SERVE_TICKS-1: clear the counter and go to PLAY. The ball does not move on that tick.
  - First movement happens on the next tick.
- PLAY, on each tick; the y and x rules apply in the same tick:
  - Y, moving down: if y + BALL_R + 1 > Y_BOT, flip dir_y and set y ← y − 1. Otherwise y ← y + 1.
  - Y, moving up: if y − BALL_R − 1 < Y_TOP, flip dir_y and set y ← y + 1. Otherwise y ← y − 1.
  - X, moving left, face contact when x − BALL_R − 1 == LPAD_X:
    - If |y − ypos_left| ≤ PAD_HALF + BALL_R (current y, before update): flip dir_x, x ← x + 1, hit = 1 for that cycle.
    - Otherwise x ← x − 1. The ball passes; face contact is an equality test and does not re-trigger.
  - X, moving right: symmetric, using x + BALL_R + 1 == RPAD_X and ypos_right.
  - Miss: moving left with x − BALL_R == X_MIN, or moving right with x + BALL_R == X_MAX.
    - The position is not updated.
    - The scorer is the opposite player. Go to POINT on the next cycle.
    - The miss check has priority over the paddle check.
- POINT, exactly one clk regardless of tick:
  - Increment the scorer's score and pulse point.
  - If the new score == WIN_SCORE, go to OVER. Otherwise go to SERVE.
  - Entering SERVE:
    - Ball recentred.
    - dir_x points toward the player who conceded.
    - dir_y toggles from its value at the previous serve.
- OVER:
  - Ball held at the centre; game_over = 1; scores frozen.
  - Ticks are ignored. Leave OVER only via rst.
- Between ticks: all registers hold, and hit and point are 0.
- Scores never exceed WIN_SCORE, and are never incremented in any state other than POINT.

Test Plan:
- Serve timing: rst, then tick every cycle.
  - Ball stays at (320,274) for 60 ticks.
  - After tick 61 the ball is at (321,275).
- Bottom wall bounce: continue from the serve test with ypos_right = 200.
  - After play tick 233 the ball is at (553,507).
  - After play tick 234 the ball is at (554,506), with dir_y up.
- Right paddle hit: hold ypos_right = 485.
  - Play tick 256 sees the ball at (575,485): hit pulses once.
  - After that tick the ball is at (574,484), moving left.
- Right miss: same stimulus with ypos_right = 200.
  - No hit; the ball reaches (635,425) after play tick 315.
  - Tick 316: point pulses, score_left = 1.
  - Ball recentred and served toward the right.
- Game over: force 7 left misses.
  - score_right = 7 and game_over = 1.
  - Further ticks leave the ball at (320,274).
  - A subsequent rst clears scores and game_over.
- Reset mid-play: assert rst for 1 cycle at an arbitrary PLAY position.
  - Next cycle: ball at (320,274), scores 0, state SERVE, counter restarts at 0.
